// File: rtl/dd_capture_pkg.sv
// Shared types and constants for the capture sequencer slice.
package dd_capture_pkg;

    localparam int unsigned SAMPLE_W         = 10;
    localparam int unsigned BUFFER_WORDS_DEF = 8192;
    localparam int unsigned COUNT_W          = 16;
    localparam int unsigned OVF_W            = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        RUN   = 2'd2,
        FAULT = 2'd3
    } captureState_t;

    // Saturating increment for the overflow event counter.
    function automatic logic [OVF_W-1:0] satInc(input logic [OVF_W-1:0] value);
        return (value == '1) ? value : value + OVF_W'(1);
    endfunction

endpackage

// File: rtl/capture_sequencer_if.sv
// Sample/control bus between the capture sequencer and the ping-pong buffer.
interface capture_sequencer_if;
    import dd_capture_pkg::*;

    logic [SAMPLE_W-1:0] adcData;
    logic                bufferOverflow;
    logic [SAMPLE_W-1:0] bufferDataIn;
    logic                bufferReset_n;

    modport master (
        input  adcData,
        input  bufferOverflow,
        output bufferDataIn,
        output bufferReset_n
    );

    modport slave (
        output adcData,
        output bufferOverflow,
        input  bufferDataIn,
        input  bufferReset_n
    );
endinterface

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser into the writeClock domain.
module sync_2ff (
    input  logic writeClock,
    input  logic nReset,
    input  logic d,
    output logic q
);
    logic meta;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge writeClock or negedge nReset) begin
        if (!nReset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/capture_sequencer.sv
// Write-clock-domain sequencer for the ping-pong capture buffer.
// Starts/stops capture on whole-buffer boundaries, counts buffers and
// overflow events, and optionally aborts after too many overflows.
// Build option: define CAPTURE_TEST_PATTERN_EN to add the test-pattern source.
module capture_sequencer
    import dd_capture_pkg::*;
#(
    parameter int unsigned BUFFER_WORDS  = BUFFER_WORDS_DEF,
    parameter int unsigned RESET_HOLD    = 4,
    parameter int unsigned MAX_OVERFLOWS = 0
) (
    input  logic                  writeClock,
    input  logic                  nReset,
    input  logic                  collectData,
    input  logic                  testMode,
    capture_sequencer_if.master   bufIf,
    output logic                  running,
    output logic [COUNT_W-1:0]    bufferCount,
    output logic [OVF_W-1:0]      overflowCount,
    output logic                  faultSticky
);
    localparam int unsigned WORD_W = (BUFFER_WORDS > 1) ? $clog2(BUFFER_WORDS) : 1;
    localparam int unsigned HOLD_W = $clog2(RESET_HOLD + 1);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(BUFFER_WORDS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
    localparam logic [OVF_W-1:0]  OVF_LIMIT = OVF_W'(MAX_OVERFLOWS);

    captureState_t      state;
    logic [WORD_W-1:0]  wordCount;
    logic [HOLD_W-1:0]  holdCounter;
    logic               collectSync;
    logic               ovfReg;
    logic               ovfRise;
    logic [OVF_W-1:0]   ovfNext;
    logic               ovfFault;
    logic               atBoundary;

    sync_2ff collectSyncInst (
        .writeClock (writeClock),
        .nReset     (nReset),
        .d          (collectData),
        .q          (collectSync)
    );

    // Overflow edge history; only a new assertion counts as an event.
    always_ff @(posedge writeClock or negedge nReset) begin
        if (!nReset) begin
            ovfReg <= 1'b0;
        end else begin
            ovfReg <= bufIf.bufferOverflow;
        end
    end

    assign ovfRise    = bufIf.bufferOverflow & ~ovfReg;
    assign ovfNext    = satInc(overflowCount);
    assign ovfFault   = (MAX_OVERFLOWS != 0) && ovfRise && (ovfNext == OVF_LIMIT);
    assign atBoundary = (wordCount == WORD_LAST);

    // Sequencer state machine with its registered control outputs.
    always_ff @(posedge writeClock or negedge nReset) begin
        if (!nReset) begin
            state               <= IDLE;
            wordCount           <= '0;
            holdCounter         <= '0;
            bufIf.bufferReset_n <= 1'b0;
            running             <= 1'b0;
            bufferCount         <= '0;
            overflowCount       <= '0;
            faultSticky         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bufIf.bufferReset_n <= 1'b0;
                    running             <= 1'b0;
                    if (collectSync) begin
                        state         <= ARM;
                        bufferCount   <= '0;
                        overflowCount <= '0;
                        faultSticky   <= 1'b0;
                        holdCounter   <= '0;
                    end
                end
                ARM: begin
                    bufIf.bufferReset_n <= 1'b0;
                    running             <= 1'b0;
                    if (!collectSync) begin
                        state <= IDLE;
                    end else if (holdCounter == HOLD_LAST) begin
                        state               <= RUN;
                        wordCount           <= '0;
                        bufIf.bufferReset_n <= 1'b1;
                        running             <= 1'b1;
                    end else begin
                        holdCounter <= holdCounter + HOLD_W'(1);
                    end
                end
                RUN: begin
                    if (atBoundary) begin
                        wordCount   <= '0;
                        bufferCount <= bufferCount + COUNT_W'(1);
                    end else begin
                        wordCount <= wordCount + WORD_W'(1);
                    end
                    if (ovfRise) begin
                        overflowCount <= ovfNext;
                    end
                    // An overflow abort wins over a boundary stop in the same cycle.
                    if (ovfFault) begin
                        state               <= FAULT;
                        bufIf.bufferReset_n <= 1'b0;
                        running             <= 1'b0;
                        faultSticky         <= 1'b1;
                    end else if (atBoundary && !collectSync) begin
                        state               <= IDLE;
                        bufIf.bufferReset_n <= 1'b0;
                        running             <= 1'b0;
                    end
                end
                FAULT: begin
                    bufIf.bufferReset_n <= 1'b0;
                    running             <= 1'b0;
                    faultSticky         <= 1'b1;
                    if (!collectSync) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CAPTURE_TEST_PATTERN_EN
    logic                testSync;
    logic [SAMPLE_W-1:0] testCounter;

    sync_2ff testSyncInst (
        .writeClock (writeClock),
        .nReset     (nReset),
        .d          (testMode),
        .q          (testSync)
    );

    // Sample register with ramp source; ramp restarts on every new arm.
    always_ff @(posedge writeClock or negedge nReset) begin
        if (!nReset) begin
            testCounter        <= '0;
            bufIf.bufferDataIn <= '0;
        end else begin
            if (state == IDLE && collectSync) begin
                testCounter <= '0;
            end else if (state == RUN) begin
                testCounter <= testCounter + SAMPLE_W'(1);
            end
            if (state == RUN) begin
                bufIf.bufferDataIn <= testSync ? testCounter : bufIf.adcData;
            end else begin
                bufIf.bufferDataIn <= '0;
            end
        end
    end
`else
    logic unusedTestMode;
    assign unusedTestMode = testMode;

    // Sample register; zero outside capture.
    always_ff @(posedge writeClock or negedge nReset) begin
        if (!nReset) begin
            bufIf.bufferDataIn <= '0;
        end else if (state == RUN) begin
            bufIf.bufferDataIn <= bufIf.adcData;
        end else begin
            bufIf.bufferDataIn <= '0;
        end
    end
`endif

endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
- Write-clock-domain controller that sequences the ping-pong capture buffer.
- Synchronises the host's collect request and selects ADC or test-pattern source.
- Holds the buffer in reset while idle and starts/stops capture only on whole 8192-word buffer boundaries.
- Counts completed buffers and overflow events; aborts capture after too many overflows.

Parameters:
- BUFFER_WORDS, 8192, words per buffer; boundary reached when wordCount == BUFFER_WORDS-1.
- RESET_HOLD, 4, writeClock cycles bufferReset_n held low in ARM (>=1).
- MAX_OVERFLOWS, 0, overflow count that forces FAULT; 0 disables the abort.

Ports:
- nReset  input  1  asynchronous, active-low reset.
- writeClock  input  1  sample/write clock; all logic in this domain.
- collectData  input  1  asynchronous host collect request; level sensitive.
- testMode  input  1  asynchronous; 1 selects test pattern.
- adcData  input  10  raw ADC sample.
- bufferOverflow  input  1  overflow pulse/hold from the buffer block.
- bufferDataIn  output  10  registered sample to the buffer.
- bufferReset_n  output  1  active-low reset to the buffer.
- running  output  1  high in RUN.
- bufferCount  output  16  completed buffers since last start; wraps.
- overflowCount  output  8  overflow rising edges since last start; saturates at 255.
- faultSticky  output  1  set on entry to FAULT; cleared on the next IDLE->ARM.

Behaviour:
- Reset values: bufferDataIn=0, bufferReset_n=0, running=0, bufferCount=0, overflowCount=0, faultSticky=0. State is IDLE, synchronisers are 0, wordCount=0, testCounter=0.
- Synchronisers:
  - collectData and testMode each pass through a 2-flop synchroniser (collect_s, test_s).
  - bufferOverflow passes through a 1-flop register for edge detection.
- State machine: IDLE, ARM, RUN, FAULT.
  - IDLE: bufferReset_n=0. On collect_s=1, go to ARM; clear bufferCount, overflowCount, faultSticky and holdCounter.
  - ARM: bufferReset_n=0; holdCounter increments each cycle.
    - If collect_s=0, return to IDLE immediately.
    - When holdCounter == RESET_HOLD-1, go to RUN with wordCount=0.
  - RUN: bufferReset_n=1, running=1; wordCount increments every cycle.
    - At wordCount == BUFFER_WORDS-1: wordCount wraps to 0 and bufferCount += 1 (wraps at 65535->0).
    - In that same cycle, if collect_s=0, go to IDLE (bufferReset_n=0 next cycle).
    - A collect drop mid-buffer does not stop capture before the boundary; re-assertion before the boundary cancels the stop.
  - FAULT: bufferReset_n=0, faultSticky=1. Stay until collect_s=0, then go to IDLE.
- Overflow:
  - A rising edge of the registered bufferOverflow while in RUN increments overflowCount (saturating at 255). Edges outside RUN are ignored.
  - If MAX_OVERFLOWS != 0 and the incremented value equals MAX_OVERFLOWS, go to FAULT next cycle. FAULT takes priority over a simultaneous boundary stop.
- Datapath:
  - bufferDataIn <= (test_s ? testCounter : adcData) each cycle; latency 1 cycle.
  - While state != RUN, bufferDataIn is forced to 0.
  - testCounter increments only in RUN, 0..1023 wrapping; it resets to 0 on entry to ARM.
- Asserting nReset mid-RUN forces all reset values immediately, asynchronously.

Optional Feature:
- Macro CAPTURE_TEST_PATTERN_EN.
- Defined: test-pattern source as described.
- Undefined: testMode is ignored, its synchroniser and testCounter are omitted, and bufferDataIn always carries registered adcData in RUN.

Decomposition:
- Shared package dd_capture_pkg holds:
  - state encoding (IDLE=2'd0, ARM=2'd1, RUN=2'd2, FAULT=2'd3);
  - BUFFER_WORDS default;
  - sample width 10.
- One sub-module, sync_2ff: a 1-bit two-flop synchroniser with async active-low reset, instantiated for collectData and testMode.

Test Plan:
- Reset, then collectData=1 held, RESET_HOLD=4 -> bufferReset_n rises 2 (sync) + 1 + 4 cycles after collect; running=1; wordCount=0.
- RUN with testMode=1 -> bufferDataIn sequence 0,1,2,…,1023,0; bufferCount=1 after 8192 RUN cycles, 2 after 16384.
- Drop collectData at wordCount=100 -> running stays 1 until wordCount=8191, then bufferReset_n=0 and bufferDataIn=0 next cycle; bufferCount=1.
- MAX_OVERFLOWS=3, three overflow pulses in RUN -> overflowCount=3, FAULT entered, faultSticky=1, bufferReset_n=0. Drop collect -> IDLE; faultSticky stays 1 until the next start.
- 300 overflow pulses with MAX_OVERFLOWS=0 -> overflowCount saturates at 255, no FAULT.
- nReset asserted mid-buffer (wordCount=4000) -> all outputs at reset values with no clock edge. Restart -> bufferCount=0.
